// File: rtl/frame_capture.sv
// Captures length-prefixed frames after each sync detect into a byte FIFO and replays them on a valid/ready stream.
// Latency: a payload byte is visible on o_data one cycle after it is written. Input has no backpressure; a frame that does not fit is dropped at its header.
module frame_capture #(
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_LEN    = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_data,
    input  logic        i_detected,
    output logic [7:0]  o_data,
    output logic        o_last,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_drop,
    output logic [15:0] o_frame_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 9;
    localparam logic [7:0] MAX_L = 8'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, CAPTURE, DISCARD} state_t;

    state_t        state_q;
    logic [7:0]    rem_q;
    logic          drop_q;
    logic [15:0]   frame_count_q;
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_ptr_d;
    logic [8:0]    mem_q [FIFO_DEPTH];

    logic [AW:0]   occupancy;
    logic [CW-1:0] free_space;
    logic          hdr_too_long;
    logic          hdr_no_room;
    logic          fifo_empty;
    logic          rd_en;

    assign occupancy    = wr_ptr_q - rd_ptr_q;
    assign free_space   = CW'(FIFO_DEPTH) - CW'(occupancy);
    assign hdr_too_long = (i_data > MAX_L);
    assign hdr_no_room  = (free_space < CW'(i_data));
    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign rd_en        = !fifo_empty && i_ready;
    assign rd_ptr_d     = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // Free space is checked once at the header, so the write side never needs a full test.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            rem_q         <= 8'd0;
            drop_q        <= 1'b0;
            frame_count_q <= 16'd0;
            wr_ptr_q      <= '0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_detected) begin
                        if (i_data == 8'd0) begin
                            drop_q <= 1'b1;
                        end else if (hdr_too_long || hdr_no_room) begin
                            drop_q  <= 1'b1;
                            rem_q   <= i_data;
                            state_q <= DISCARD;
                        end else begin
                            rem_q   <= i_data;
                            state_q <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    rem_q    <= rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        frame_count_q <= frame_count_q + 16'd1;
                        state_q       <= IDLE;
                    end
                end
                DISCARD: begin
                    rem_q <= rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (state_q == CAPTURE) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {(rem_q == 8'd1), i_data};
        end
    end

    // Head entry is read straight from storage so the first byte falls through without an extra stage.
    assign o_valid       = !fifo_empty;
    assign o_data        = o_valid ? mem_q[rd_ptr_q[AW-1:0]][7:0] : 8'd0;
    assign o_last        = o_valid ? mem_q[rd_ptr_q[AW-1:0]][8] : 1'b0;
    assign o_busy        = (state_q != IDLE);
    assign o_drop        = drop_q;
    assign o_frame_count = frame_count_q;

endmodule

// File: doc/frame_capture.md
Name: frame_capture

Overview:
- Sits directly downstream of the byte-stream pattern detector (pdetect). Shares its i_data byte stream and takes its o_detected pulse as i_detected.
- On each detected sync pattern, reads a length byte and then that many payload bytes into an internal FIFO.
- Presents captured frames on a byte-wide valid/ready output stream, with a last flag on the final byte of each frame.
- Drops frames with an illegal length, and frames that cannot fit in the FIFO.

Parameters:
FIFO_DEPTH, 64, payload FIFO depth in bytes; power of two, >= MAX_LEN
MAX_LEN, 32, largest accepted payload length in bytes; 1..255

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous, active-high reset
i_data  input  8  byte stream, one byte per cycle, no backpressure (same stream the detector sees)
i_detected  input  1  one-cycle pulse from the pattern detector
o_data  output  8  output byte
o_last  output  1  o_data is the final byte of its frame
o_valid  output  1  o_data/o_last valid
i_ready  input  1  downstream accepts the byte when o_valid && i_ready
o_busy  output  1  state != IDLE
o_drop  output  1  one-cycle pulse when a frame is rejected
o_frame_count  output  16  count of frames fully written to the FIFO; wraps 0xFFFF -> 0x0000

Behaviour:
- Reset (async assert, sync release) sets: state IDLE, FIFO empty, o_valid=0, o_last=0, o_data=0, o_busy=0, o_drop=0, o_frame_count=0.
- Timing contract: a cycle with i_detected=1 carries the length byte L on i_data in that same cycle. Payload bytes follow on the next L consecutive cycles.
- States: IDLE, CAPTURE, DISCARD. A remaining-byte counter rem is 8 bits.
- IDLE, i_detected=1, any of the following: L==0, L>MAX_LEN, or FIFO free space (sampled this cycle, before any same-cycle read) < L. Result: o_drop=1 next cycle, and the FIFO is not written.
  - L==0 stays in IDLE.
  - The other two cases go to DISCARD with rem=L.
- IDLE, i_detected=1, otherwise: go to CAPTURE with rem=L.
- IDLE, i_detected=0: stay in IDLE.
- CAPTURE:
  - Each cycle, write i_data to the FIFO and decrement rem.
  - The write with rem==1 sets that entry's last flag, increments o_frame_count, and returns to IDLE.
- DISCARD: each cycle decrement rem; on rem==1 return to IDLE. No FIFO writes.
- i_detected is ignored in CAPTURE and DISCARD. A pattern occurring inside payload is payload data.
- Because free space is checked at the header and the FIFO only drains during a frame, overflow cannot occur mid-frame. The FIFO write side never sees full during CAPTURE.
- A new i_detected is honoured in the first cycle after the frame's last byte, i.e. back-to-back frames are legal.
- Output is first-word-fall-through.
  - Written byte appears with o_valid=1 no earlier than the cycle after the write (1-cycle latency).
  - o_valid=1 whenever the FIFO is non-empty.
  - o_data/o_last hold stable while o_valid && !i_ready.
  - Simultaneous read and write are supported, including when the FIFO is full or empty.
- Count and address arithmetic: FIFO pointers are log2(FIFO_DEPTH)+1 bits; free space = FIFO_DEPTH − occupancy. Compare free space against L zero-extended.
- Reset mid-frame:
  - FIFO contents are discarded, including partial or complete frames.
  - No o_drop pulse.
  - Capture restarts only on the next i_detected after reset release.

Test Plan:
- Basic frame, i_ready=1:
  - Stimulus: i_detected with L=3, then 0x11, 0x22, 0x33.
  - Response: o_valid rises the cycle after the 0x11 write; outputs 0x11, 0x22, 0x33; o_last=1 only with 0x33; o_frame_count=1; o_busy high for exactly 3 cycles.
- Illegal lengths:
  - Stimulus 1: L=0. Response: o_drop one pulse, o_busy stays 0, no output.
  - Stimulus 2: L=40 (>MAX_LEN). Response: o_drop one pulse, o_busy high 40 cycles, no output, o_frame_count unchanged.
- Backpressure and fit check, i_ready=0:
  - Stimulus: frames with L=32, L=32, then L=1.
  - Response: first two frames accepted (free 64, then 32); third drops with o_drop, since free space is 0.
  - Then raise i_ready. Response: 64 bytes drain in order; o_last on bytes 32 and 64; o_frame_count=2.
- Pattern inside payload:
  - Stimulus: L=5, with i_detected pulsed on payload byte 3.
  - Response: all 5 bytes output unchanged; no extra frame; no o_drop.
- Stall stability:
  - Stimulus: toggle i_ready 1,0,0,1 while a 4-byte frame drains.
  - Response: o_data/o_last/o_valid unchanged across stall cycles; each byte delivered exactly once.
- Reset mid-operation:
  - Stimulus: assert i_rst asynchronously during payload byte 2 of L=5, with an earlier frame still queued.
  - Response: o_valid=0 and o_frame_count=0 immediately.
  - Then send a new L=2 frame 0xAA, 0xBB. Response: exactly 0xAA, 0xBB(last) output.
